// File: rtl/muldiv_arbiter_if.sv
// -----------------------------------------------------------------------------
// muldiv_arbiter_if
// Bundles every handshake and bus signal of the mul/div arbiter: the two
// request channels, the response channel and the launch/complete interface
// towards the shared iterative multiply/divide unit.
//
// Modports:
//   slave  - the arbiter side (accepts requests, drives responses and the
//            unit launch bus, receives unit completion)
//   master - the environment side (requesters, response consumer and the
//            mul/div unit)
//
// Signals:
//   req0_valid/req1_valid    request pending
//   req0_ready/req1_ready    request accepted this cycle
//   req0_opcode/req1_opcode  5-bit ALU opcode
//   req0_op1/op2, req1_op1/op2  32-bit operands
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   owning requester
//   rsp_data                 32-bit result
//   rsp_error                illegal opcode or timeout
//   unit_start               one-cycle launch pulse
//   unit_opcode/op1/op2      latched operation towards the unit
//   unit_complete            unit done flag (level)
//   unit_result              unit result, valid while unit_complete is high
// -----------------------------------------------------------------------------
interface muldiv_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_opcode;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_opcode;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        unit_start;
    logic [4:0]  unit_opcode;
    logic [31:0] unit_op1;
    logic [31:0] unit_op2;
    logic        unit_complete;
    logic [31:0] unit_result;

    modport slave (
        input  req0_valid, req0_opcode, req0_op1, req0_op2,
        input  req1_valid, req1_opcode, req1_op1, req1_op2,
        input  rsp_ready, unit_complete, unit_result,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_error,
        output unit_start, unit_opcode, unit_op1, unit_op2
    );

    modport master (
        output req0_valid, req0_opcode, req0_op1, req0_op2,
        output req1_valid, req1_opcode, req1_op1, req1_op2,
        output rsp_ready, unit_complete, unit_result,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_error,
        input  unit_start, unit_opcode, unit_op1, unit_op2
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// muldiv_arbiter
// Two-port round-robin arbiter and sequencer for the shared iterative
// multiply/divide unit. One operation is in flight at a time: grant, launch,
// wait for the unit's completion flag, then hold the response until the
// consumer takes it. Opcodes outside the mul/div range are answered with an
// error response without launching the unit.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  synchronous active-low reset
//   bus    muldiv_arbiter_if.slave (requests, response, unit bus)
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles before abort (timeout build only)
//   GUARD_CYCLES    WAIT cycles during which unit_complete is ignored (1..7)
//
// Optional feature: define MULDIV_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles with an error response.
// -----------------------------------------------------------------------------
module muldiv_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GUARD_CYCLES   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    muldiv_arbiter_if.slave         bus
);

`ifdef MULDIV_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 3) ? $clog2(TIMEOUT_CYCLES + 1) : 3;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`else
    localparam int CNT_W = 3;
`endif
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic             grant_valid;
    logic             grant_id;
    logic [4:0]       sel_opcode;
    logic [31:0]      sel_op1;
    logic [31:0]      sel_op2;
    logic             sel_legal;
    logic             qualified;
    logic             capture;
    logic             timeout_hit;

    // Mul family 2..5 and div family 6..9 form one contiguous legal range.
    function automatic logic is_legal(input logic [4:0] opc);
        return (opc >= 5'd2) && (opc <= 5'd9);
    endfunction

    // Request selection: a lone requester always wins, a tie goes to the
    // requester that did not win last time.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
        sel_opcode = grant_id ? bus.req1_opcode : bus.req0_opcode;
        sel_op1    = grant_id ? bus.req1_op1    : bus.req0_op1;
        sel_op2    = grant_id ? bus.req1_op2    : bus.req0_op2;
        sel_legal  = is_legal(sel_opcode);
    end

    // Completion is only trusted once the guard window has passed, which
    // filters a done flag left over from the previous operation.
    assign qualified = bus.unit_complete && (wait_cnt >= GUARD_CNT);

    // Next-state and handshake outputs. Ready is masked during reset so a
    // request is never reported accepted on an edge that discards it.
    always_comb begin
        state_next     = state;
        grant_valid    = 1'b0;
        capture        = 1'b0;
        timeout_hit    = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.unit_start = 1'b0;
        bus.rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    grant_valid    = 1'b1;
                    bus.req0_ready = rst_n && !grant_id;
                    bus.req1_ready = rst_n && grant_id;
                    state_next     = sel_legal ? LAUNCH : RESP;
                end
            end
            LAUNCH: begin
                bus.unit_start = 1'b1;
                state_next     = WAIT;
            end
            WAIT: begin
                if (qualified) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
`ifdef MULDIV_ARB_TIMEOUT_EN
                else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
`endif
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, arbitration history, latched operation, wait counter and the
    // response registers. An illegal grant loads the error response directly
    // so it is ready the cycle after the grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            wait_cnt        <= '0;
            bus.unit_opcode <= '0;
            bus.unit_op1    <= '0;
            bus.unit_op2    <= '0;
            bus.rsp_id      <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_error   <= 1'b0;
        end else begin
            state <= state_next;

            if (grant_valid) begin
                last_grant      <= grant_id;
                bus.unit_opcode <= sel_opcode;
                bus.unit_op1    <= sel_op1;
                bus.unit_op2    <= sel_op2;
                bus.rsp_id      <= grant_id;
                if (!sel_legal) begin
                    bus.rsp_data  <= '0;
                    bus.rsp_error <= 1'b1;
                end
            end

            if (state == LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
`ifdef MULDIV_ARB_TIMEOUT_EN
                wait_cnt <= wait_cnt + 1'b1;
`else
                if (wait_cnt < GUARD_CNT) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
`endif
            end

            if (capture) begin
                bus.rsp_data  <= bus.unit_result;
                bus.rsp_error <= 1'b0;
            end
            if (timeout_hit) begin
                bus.rsp_data  <= '0;
                bus.rsp_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_arbiter
// Directed bench for muldiv_arbiter (GUARD_CYCLES=2, TIMEOUT_CYCLES=64).
// A table of single transactions with hand-computed results and latencies is
// replayed in a loop; stale-completion, lost-completion, backpressure,
// round-robin, reset-in-WAIT and (timeout build) timeout cases follow as
// hand-written sequences. The bench plays requester, consumer and unit.
// -----------------------------------------------------------------------------
module tb_muldiv_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muldiv_arbiter_if bus();

    muldiv_arbiter #(
        .TIMEOUT_CYCLES (64),
        .GUARD_CYCLES   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        id;
        logic [4:0]  opcode;
        logic [31:0] op1;
        logic [31:0] op2;
        int          lat;
        logic [31:0] result;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_starts;
    } vec_t;

    vec_t vecs[7];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are sampled
    // and inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.req0_valid    = 1'b0;
        bus.req0_opcode   = '0;
        bus.req0_op1      = '0;
        bus.req0_op2      = '0;
        bus.req1_valid    = 1'b0;
        bus.req1_opcode   = '0;
        bus.req1_op1      = '0;
        bus.req1_op2      = '0;
        bus.rsp_ready     = 1'b0;
        bus.unit_complete = 1'b0;
        bus.unit_result   = '0;
    endtask

    task automatic driveReq(input logic id, input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            bus.req1_opcode = opc;
            bus.req1_op1    = a;
            bus.req1_op2    = b;
            bus.req1_valid  = 1'b1;
        end else begin
            bus.req0_opcode = opc;
            bus.req0_op1    = a;
            bus.req0_op2    = b;
            bus.req0_valid  = 1'b1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'd0);
        checkOutput({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        checkOutput({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        checkOutput({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'd0);
        checkOutput({tag, "_unit_start"}, 32'(bus.unit_start), 32'd0);
        checkOutput({tag, "_unit_opcode"}, 32'(bus.unit_opcode), 32'd0);
        checkOutput({tag, "_unit_op1"}, bus.unit_op1, 32'd0);
        checkOutput({tag, "_unit_op2"}, bus.unit_op2, 32'd0);
    endtask

    // Called one sample after the grant edge (cycle 1). Acts as the unit:
    // raises unit_complete lat cycles after the start pulse (lat=0: never).
    // Returns the cycle at which rsp_valid was seen (-1 if the bound expired).
    task automatic serve(input int lat, input logic [31:0] result, output int rsp_cyc, output int starts);
        int start_cyc;
        starts    = 0;
        start_cyc = -1;
        rsp_cyc   = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (bus.unit_start) begin
                starts++;
                start_cyc = cyc;
            end
            if (lat > 0 && start_cyc >= 0 && cyc == start_cyc + lat) begin
                bus.unit_complete = 1'b1;
                bus.unit_result   = result;
            end
            if (bus.rsp_valid) begin
                rsp_cyc = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic finishRsp();
        bus.unit_complete = 1'b0;
        bus.rsp_ready     = 1'b1;
        step();
        bus.rsp_ready     = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int    rc;
        int    st;
        string tag;
        tag = $sformatf("vec%0d", idx);
        driveReq(v.id, v.opcode, v.op1, v.op2);
        #1;
        checkOutput({tag, "_ready"}, 32'(v.id ? bus.req1_ready : bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        serve(v.lat, v.result, rc, st);
        checkOutput({tag, "_latency"}, 32'(rc), 32'(v.exp_lat));
        checkOutput({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(v.id));
        checkOutput({tag, "_rsp_data"}, bus.rsp_data, v.exp_data);
        checkOutput({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'(v.exp_err));
        checkOutput({tag, "_starts"}, 32'(st), 32'(v.exp_starts));
        if (!v.exp_err) begin
            checkOutput({tag, "_unit_opcode"}, 32'(bus.unit_opcode), 32'(v.opcode));
            checkOutput({tag, "_unit_op1"}, bus.unit_op1, v.op1);
            checkOutput({tag, "_unit_op2"}, bus.unit_op2, v.op2);
        end
        finishRsp();
        checkOutput({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    // One round-robin transaction with both requesters permanently valid.
    task automatic rrStep(input logic exp_id, input int k);
        int rc;
        int st;
        #1;
        checkOutput($sformatf("rr%0d_req0_ready", k), 32'(bus.req0_ready), 32'(!exp_id));
        checkOutput($sformatf("rr%0d_req1_ready", k), 32'(bus.req1_ready), 32'(exp_id));
        step();
        serve(3, 32'h100 + 32'(k), rc, st);
        checkOutput($sformatf("rr%0d_rsp_id", k), 32'(bus.rsp_id), 32'(exp_id));
        checkOutput($sformatf("rr%0d_rsp_data", k), bus.rsp_data, 32'h100 + 32'(k));
        finishRsp();
    endtask

    initial begin
        int rc;
        int st;
        int bad_cycles;

        // Latency = 2 + N WAIT cycles; completion raised lat cycles after the
        // start pulse gives N = lat when lat >= GUARD_CYCLES+1.
        vecs[0] = '{1'b0, 5'b00010, 32'd7,   32'd6, 5, 32'd42,         7,  32'd42,         1'b0, 1};
        vecs[1] = '{1'b1, 5'b00000, 32'd3,   32'd4, 0, 32'd0,          1,  32'd0,          1'b1, 0};
        vecs[2] = '{1'b1, 5'b00111, 32'd100, 32'd7, 3, 32'd14,         5,  32'd14,         1'b0, 1};
        vecs[3] = '{1'b0, 5'b01001, 32'd10,  32'd3, 8, 32'd1,          10, 32'd1,          1'b0, 1};
        vecs[4] = '{1'b0, 5'b01010, 32'd1,   32'd2, 0, 32'd0,          1,  32'd0,          1'b1, 0};
        vecs[5] = '{1'b1, 5'b00001, 32'd9,   32'd9, 0, 32'd0,          1,  32'd0,          1'b1, 0};
        vecs[6] = '{1'b1, 5'b00101, 32'd2,   32'd1, 3, 32'hFFFF_FFFE,  5,  32'hFFFF_FFFE,  1'b0, 1};

        idleInputs();
        rst_n = 1'b0;
        step();
        step();
        checkResetValues("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Stale done flag high before launch: only the third WAIT cycle
        // (counter 2) may capture, so rsp_valid appears at cycle 5.
        bus.unit_complete = 1'b1;
        bus.unit_result   = 32'hDEAD_BEEF;
        driveReq(1'b0, 5'b00011, 32'd3, 32'd9);
        step();
        bus.req0_valid = 1'b0;
        step();
        step();
        step();
        bus.unit_result = 32'h1234_5678;
        checkOutput("stale_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
        step();
        checkOutput("stale_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("stale_rsp_data", bus.rsp_data, 32'h1234_5678);
        finishRsp();

        // Completion pulse inside the guard window is lost; a later one is taken.
        driveReq(1'b1, 5'b00100, 32'd5, 32'd5);
        step();
        bus.req1_valid = 1'b0;
        step();
        bus.unit_complete = 1'b1;
        bus.unit_result   = 32'd99;
        step();
        bus.unit_complete = 1'b0;
        bad_cycles = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            if (bus.rsp_valid) bad_cycles++;
        end
        checkOutput("guard_lost_no_rsp", 32'(bad_cycles), 32'd0);
        bus.unit_complete = 1'b1;
        bus.unit_result   = 32'd25;
        step();
        checkOutput("guard_late_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("guard_late_rsp_data", bus.rsp_data, 32'd25);
        finishRsp();

        // Backpressure: response held 10 cycles with both requesters waiting,
        // then the grant follows right after the handshake.
        driveReq(1'b0, 5'b00010, 32'd11, 32'd3);
        step();
        bus.req0_valid = 1'b0;
        serve(4, 32'd33, rc, st);
        checkOutput("bp_latency", 32'(rc), 32'd6);
        bus.unit_complete = 1'b0;
        driveReq(1'b0, 5'b00110, 32'd20, 32'd4);
        driveReq(1'b1, 5'b00111, 32'd21, 32'd3);
        bad_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!bus.rsp_valid || bus.rsp_data !== 32'd33 || bus.rsp_id !== 1'b0 ||
                bus.rsp_error !== 1'b0 || bus.req0_ready || bus.req1_ready) begin
                bad_cycles++;
            end
            step();
        end
        checkOutput("bp_stable_cycles", 32'(bad_cycles), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput("bp_next_grant_req1", 32'(bus.req1_ready), 32'd1);
        checkOutput("bp_next_grant_req0", 32'(bus.req0_ready), 32'd0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        serve(3, 32'd7, rc, st);
        checkOutput("bp_second_id", 32'(bus.rsp_id), 32'd1);
        checkOutput("bp_second_data", bus.rsp_data, 32'd7);
        finishRsp();

        // Round robin from a fresh reset: 0,1,0,1.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        driveReq(1'b0, 5'b00110, 32'd8, 32'd2);
        driveReq(1'b1, 5'b00110, 32'd9, 32'd3);
        rrStep(1'b0, 0);
        rrStep(1'b1, 1);
        rrStep(1'b0, 2);
        rrStep(1'b1, 3);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();

        // Reset while in WAIT, then make sure the launch is not repeated.
        driveReq(1'b1, 5'b01000, 32'h55, 32'h66);
        step();
        bus.req1_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        checkResetValues("wait_rst");
        rst_n = 1'b1;
        bad_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.unit_start || bus.rsp_valid) bad_cycles++;
        end
        checkOutput("wait_rst_no_relaunch", 32'(bad_cycles), 32'd0);

`ifdef MULDIV_ARB_TIMEOUT_EN
        // Unit never completes: error response after 64 WAIT cycles.
        driveReq(1'b0, 5'b00010, 32'd1, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        serve(0, 32'd0, rc, st);
        checkOutput("timeout_latency", 32'(rc), 32'd66);
        checkOutput("timeout_error", 32'(bus.rsp_error), 32'd1);
        checkOutput("timeout_data", bus.rsp_data, 32'd0);
        finishRsp();
        applyStimulus(vecs[0], 100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Two-port arbiter and sequencer for the shared iterative multiply/divide unit behind the ALU. It accepts requests from two independent requesters, grants the unit round-robin, and launches one operation at a time. It then waits for the unit's completion flag and returns the result to the owning requester over a valid/ready response channel. Non-mul/div opcodes are rejected without touching the unit.

## Interface
- Parameters:
  - `TIMEOUT_CYCLES`, default 64: max cycles in WAIT before abort (only with `MULDIV_ARB_TIMEOUT_EN`).
  - `GUARD_CYCLES`, default 2: cycles after launch during which `unit_complete` is ignored (stale flag filter); legal range 1–7.
- Ports (one clock; reset synchronous, active-low):
  - `clk`  in  1  system clock, all state on rising edge.
  - `rst_n`  in  1  synchronous active-low reset.
  - `req0_valid` / `req1_valid`  in  1  request pending.
  - `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
  - `req0_opcode` / `req1_opcode`  in  5  ALU opcode.
  - `req0_op1`, `req0_op2`, `req1_op1`, `req1_op2`  in  32  operands.
  - `rsp_valid`  out  1  response available.
  - `rsp_ready`  in  1  consumer accepts response.
  - `rsp_id`  out  1  owning requester (0/1).
  - `rsp_data`  out  32  result.
  - `rsp_error`  out  1  illegal opcode or timeout.
  - `unit_start`  out  1  one-cycle launch pulse.
  - `unit_opcode`  out  5  latched opcode.
  - `unit_op1`, `unit_op2`  out  32  latched operands.
  - `unit_complete`  in  1  unit done flag (level).
  - `unit_result`  in  32  unit result, valid while `unit_complete`=1.

## Operation
- Legal opcodes: 5'b00010–5'b00101 (mul family), 5'b00110–5'b01001 (div family). All others are illegal.
- States: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**: if any `reqN_valid`, grant one requester and assert its `reqN_ready` for exactly that cycle. Latch opcode, operands and id.
  - Legal opcode → LAUNCH.
  - Illegal opcode → RESP with `rsp_error`=1, `rsp_data`=0.
- Arbitration: `last_grant` register, reset to 1, so requester 0 wins the first tie. With both valid, grant `~last_grant`. A single valid requester is always granted. `last_grant` updates on every grant.
- **LAUNCH**: `unit_start`=1 for one cycle; clear wait counter → WAIT.
- **WAIT**: increment counter each cycle.
  - `unit_complete` is ignored while counter < `GUARD_CYCLES`.
  - Afterwards, `unit_complete`=1 captures `unit_result` into `rsp_data`, sets `rsp_error`=0 → RESP.
- **RESP**: hold `rsp_valid`=1 with stable `rsp_id`/`rsp_data`/`rsp_error` until `rsp_ready`=1 → IDLE. No new grant is made in RESP.
- `unit_opcode`/`unit_op1`/`unit_op2` hold latched values from grant until the next grant.

## Timing
- Reset values: `req0_ready`=`req1_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_error`=0, `unit_start`=0, `unit_opcode`=0, `unit_op1`=`unit_op2`=0, state IDLE, `last_grant`=1, counter 0.
- Legal request latency, grant to `rsp_valid`: 2 + N cycles, where N = WAIT cycles (N ≥ `GUARD_CYCLES`).
- Illegal request: `rsp_valid` asserts the cycle after grant.
- Back-to-back throughput: the earliest new grant is the cycle after the `rsp_valid`&&`rsp_ready` handshake.
- `rsp_ready` asserted with `rsp_valid` completes the handshake that same cycle.
- Reset mid-operation: `rst_n`=0 in any state returns to reset values on the next edge. The in-flight response is discarded; `unit_start` is not re-issued.
- `unit_complete` arriving during the guard window, then dropping, is lost. The arbiter keeps waiting (or times out).

## Configuration
- `MULDIV_ARB_TIMEOUT_EN` defined: in WAIT, when counter reaches `TIMEOUT_CYCLES` without a qualified `unit_complete`, go to RESP with `rsp_error`=1 and `rsp_data`=32'h0000_0000.
- Not defined: no timeout logic; WAIT persists until `unit_complete`. The counter only needs to saturate at `GUARD_CYCLES`.

## Test plan
- Req0 opcode 5'b00010, op1=7, op2=6; unit completes 5 cycles after start with 42 → `rsp_id`=0, `rsp_data`=42, `rsp_error`=0, `unit_start` exactly one pulse.
- Both requesters valid every cycle with div opcode 5'b00110 → grants alternate 0,1,0,1. The first grant after reset goes to 0.
- Req1 opcode 5'b00000 → `rsp_valid` the cycle after `req1_ready`, `rsp_error`=1, `rsp_data`=0, `unit_start` never asserted.
- `unit_complete` held high from before launch (stale), with `GUARD_CYCLES`=2 → result not captured until cycle 2 of WAIT. Then capture `unit_result`=32'h1234_5678.
- With `MULDIV_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64, `unit_complete` never set → `rsp_error`=1 after 64 WAIT cycles. The next request is granted normally.
- `rsp_ready` held low for 10 cycles in RESP → outputs stable, no `reqN_ready`. Assert `rst_n`=0 in WAIT → all outputs at reset values next edge.
